// File: rtl/seq_det_sched.sv
// Shares one bit-serial sequence detector between two requesters: arbitrates, serializes
// the granted word MSB-first, counts hits. Define SEQ_DET_FIXED_PRIO_EN for fixed req0 priority.
module seq_det_sched #(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned DET_LAT = 1,
  localparam int unsigned CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             det_in,
  input  logic             det_out,
  output logic             det_rst_n,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [CNT_W-1:0] res_count
);

  localparam int unsigned CYC_W = $clog2(WIDTH + DET_LAT + 1);
  localparam logic [CYC_W-1:0] LAST_BIT    = CYC_W'(WIDTH - 1);
  localparam logic [CYC_W-1:0] LAST_SAMPLE = CYC_W'(WIDTH + DET_LAT - 1);
  localparam logic [CYC_W-1:0] FIRST_SAMPLE = CYC_W'(DET_LAT);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CYC_W-1:0] cyc, cyc_nxt;
  logic             det_in_nxt, det_rst_n_nxt, res_valid_nxt, res_id_nxt;
  logic [CNT_W-1:0] res_count_nxt;
  logic             gnt_any, gnt_id;
  logic [WIDTH-1:0] gnt_data;

  assign gnt_any  = req0_valid | req1_valid;
  assign gnt_data = gnt_id ? req1_data : req0_data;

`ifdef SEQ_DET_FIXED_PRIO_EN
  assign gnt_id = ~req0_valid;
`else
  // Tie goes to whichever requester was not served last.
  logic rr_last;
  assign gnt_id = (req0_valid & req1_valid) ? ~rr_last : req1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             rr_last <= 1'b1;
    else if (state == S_IDLE && gnt_any) rr_last <= gnt_id;
  end
`endif

  // Ready is only offered while idle and never during reset.
  assign req0_ready = (state == S_IDLE) & ~rst & gnt_any & ~gnt_id;
  assign req1_ready = (state == S_IDLE) & ~rst & gnt_any &  gnt_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      shreg     <= '0;
      cyc       <= '0;
      det_in    <= 1'b0;
      det_rst_n <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_count <= '0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cyc       <= cyc_nxt;
      det_in    <= det_in_nxt;
      det_rst_n <= det_rst_n_nxt;
      res_valid <= res_valid_nxt;
      res_id    <= res_id_nxt;
      res_count <= res_count_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    cyc_nxt       = cyc;
    det_in_nxt    = 1'b0;
    det_rst_n_nxt = 1'b0;
    res_valid_nxt = 1'b0;
    res_id_nxt    = res_id;
    res_count_nxt = res_count;
    unique case (state)
      S_IDLE: begin
        if (gnt_any) begin
          state_nxt     = S_SHIFT;
          shreg_nxt     = {gnt_data[WIDTH-2:0], 1'b0};
          det_in_nxt    = gnt_data[WIDTH-1];
          det_rst_n_nxt = 1'b1;
          cyc_nxt       = '0;
          res_id_nxt    = gnt_id;
          res_count_nxt = '0;
        end
      end
      S_SHIFT, S_DRAIN: begin
        cyc_nxt       = cyc + CYC_W'(1);
        det_rst_n_nxt = 1'b1;
        if (cyc >= FIRST_SAMPLE && det_out) res_count_nxt = res_count + CNT_W'(1);
        // Zeros shifted in keep det_in low once the word is exhausted.
        if (state == S_SHIFT) begin
          det_in_nxt = shreg[WIDTH-1];
          shreg_nxt  = {shreg[WIDTH-2:0], 1'b0};
          if (cyc == LAST_BIT) state_nxt = S_DRAIN;
        end
        if (cyc == LAST_SAMPLE) begin
          state_nxt     = S_DONE;
          det_in_nxt    = 1'b0;
          det_rst_n_nxt = 1'b0;
          res_valid_nxt = 1'b1;
        end
      end
      S_DONE: begin
        res_valid_nxt = ~res_ready;
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// Self-checking bench for seq_det_sched: job-level reference model plus directed literal checks.
module tb_seq_det_sched;
  localparam int unsigned W  = 8;
  localparam int unsigned L  = 1;
  localparam int unsigned CW = 4;
`ifdef SEQ_DET_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [W-1:0]  req0_data, req1_data;
  logic          det_in, det_out, det_rst_n;
  logic          res_valid, res_ready, res_id;
  logic [CW-1:0] res_count;

  int checks = 0;
  int errors = 0;
  int det_mode = 0;          // 0 loopback delayed 1 clk, 1 tied high, 2 random
  bit lb = 1'b0;
  bit det_rand = 1'b0;

  seq_det_sched #(.WIDTH(W), .DET_LAT(L)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .det_in(det_in), .det_out(det_out), .det_rst_n(det_rst_n),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_count(res_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) lb <= det_in;
  assign det_out = (det_mode == 0) ? lb : (det_mode == 1) ? 1'b1 : det_rand;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    det_rand = 1'($urandom);
  endtask

  // Reference model: what a job must look like, indexed by cycles since accept.
  bit           m_busy = 1'b0;
  bit           m_rr = 1'b1;
  int           m_t = 0;
  int           m_cnt = 0;
  bit           m_id = 1'b0;
  logic [W-1:0] m_data = '0;

  always @(negedge clk) begin : compare
    bit g, any;
    if (rst) begin
      chk("rst_det_in", det_in, 0);
      chk("rst_det_rst_n", det_rst_n, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_res_count", res_count, 0);
      m_busy = 1'b0;
      m_rr   = 1'b1;
    end else if (!m_busy) begin
      any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) g = FIXED ? 1'b0 : !m_rr;
      else                          g = req1_valid;
      chk("idle_det_in", det_in, 0);
      chk("idle_det_rst_n", det_rst_n, 0);
      chk("idle_res_valid", res_valid, 0);
      chk("idle_req0_ready", req0_ready, any && !g);
      chk("idle_req1_ready", req1_ready, any && g);
      if (any) begin
        m_busy = 1'b1;
        m_t    = 0;
        m_cnt  = 0;
        m_id   = g;
        m_data = g ? req1_data : req0_data;
        if (!FIXED) m_rr = g;
      end
    end else begin
      chk("busy_req0_ready", req0_ready, 0);
      chk("busy_req1_ready", req1_ready, 0);
      if (m_t < int'(W)) begin
        chk("shift_det_in", det_in, m_data[W-1-m_t]);
        chk("shift_det_rst_n", det_rst_n, 1);
        chk("shift_res_valid", res_valid, 0);
      end else if (m_t < int'(W + L)) begin
        chk("drain_det_in", det_in, 0);
        chk("drain_det_rst_n", det_rst_n, 1);
        chk("drain_res_valid", res_valid, 0);
      end else begin
        chk("done_det_in", det_in, 0);
        chk("done_det_rst_n", det_rst_n, 0);
        chk("done_res_valid", res_valid, 1);
        chk("done_res_id", res_id, m_id);
        chk("done_res_count", res_count, m_cnt);
      end
      if (m_t >= int'(L) && m_t <= int'(W - 1 + L)) m_cnt += int'(det_out);
      if (m_t >= int'(W + L)) begin
        if (res_ready) m_busy = 1'b0;
      end else begin
        m_t++;
      end
    end
  end

  task automatic wait_ready(input bit id);
    int n = 0;
    @(negedge clk);
    while (!(id ? req1_ready : req0_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", id ? req1_ready : req0_ready, 1);
  endtask

  task automatic wait_result();
    int n = 0;
    @(negedge clk);
    while (!res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_result", res_valid, 1);
  endtask

  task automatic run_job(input bit id, input logic [W-1:0] d, input int exp_cnt);
    res_ready = 1'b1;
    if (id) begin req1_data = d; req1_valid = 1'b1; end
    else    begin req0_data = d; req0_valid = 1'b1; end
    wait_ready(id);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_result();
    chk("job_res_id", res_id, id);
    chk("job_res_count", res_count, exp_cnt);
    tick();
  endtask

  initial begin : stim
    logic [W-1:0] seq_exp;
    logic [W-1:0] d;
    bit           bits [W];
    int           q[$];
    int           n;
    bit           seen;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      req0_data  = W'($urandom); req1_data  = W'($urandom);
      res_ready  = 1'($urandom);
      if (i == 0) #1;
      else tick();
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("post_rst_res_valid", res_valid, 0);
    chk("post_rst_det_rst_n", det_rst_n, 0);

    // Single job under loopback
    det_mode = 0;
    req0_data = 8'hA5; req0_valid = 1'b1;
    wait_ready(1'b0);
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      bits[i] = det_in;
    end
    seq_exp = 8'hA5;
    for (int i = 0; i < int'(W); i++) chk("a5_det_in_seq", bits[i], seq_exp[W-1-i]);
    @(negedge clk);
    chk("a5_valid_cycle9", res_valid, 0);
    @(negedge clk);
    chk("a5_valid_cycle10", res_valid, 1);
    chk("a5_res_id", res_id, 0);
    chk("a5_res_count", res_count, 4);
    tick();

    // Tie arbitration from reset
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    req0_data = W'($urandom); req1_data = W'($urandom);
    tick(); tick();
    rst = 1'b0;
    n = 0;
    while (q.size() < 4 && n < 400) begin
      @(negedge clk);
      if (req0_ready) q.push_back(0);
      if (req1_ready) q.push_back(1);
      n++;
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("tie_grant_count", q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < q.size()) chk("tie_grant_order", q[i], FIXED ? 0 : (i % 2));
    wait_result();
    tick();

    // Backpressure in DONE
    res_ready = 1'b0;
    d = W'($urandom);
    req1_data = d; req1_valid = 1'b1;
    wait_ready(1'b1);
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = W'($urandom);
    wait_result();
    chk("bp_res_id", res_id, 1);
    chk("bp_res_count", res_count, $countones(d));
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("bp_hold_valid", res_valid, 1);
      chk("bp_hold_id", res_id, 1);
      chk("bp_hold_count", res_count, $countones(d));
      chk("bp_hold_req0_ready", req0_ready, 0);
      chk("bp_hold_req1_ready", req1_ready, 0);
    end
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_xfer_valid", res_valid, 1);
    tick();
    @(negedge clk);
    chk("bp_after_valid", res_valid, 0);
    chk("bp_after_idle_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    wait_result();
    tick();

    // Abort in SHIFT cycle 3 of a req1 job
    det_mode = 0;
    req1_data = W'($urandom); req1_valid = 1'b1;
    wait_ready(1'b1);
    tick();
    req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_det_rst_n", det_rst_n, 0);
    chk("abort_det_in", det_in, 0);
    chk("abort_res_valid", res_valid, 0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    chk("abort_no_result", seen, 0);
    tick();
    run_job(1'b0, 8'hFF, 8);

    // Saturation: detector output stuck high
    det_mode = 1;
    run_job(1'b1, 8'h00, 8);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      if (i % 60 == 0) det_mode = int'($urandom_range(0, 2));
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      req0_data  = W'($urandom); req1_data  = W'($urandom);
      res_ready  = ($urandom_range(0, 3) != 0);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
